// File: rtl/framebuffer_scanout_if.sv
// Renderer/video-side bundle of the framebuffer scanout: pixel strobe,
// back-bank write port, frame handshake and the video outputs.
interface framebuffer_scanout_if #(
  parameter int ADDR_W = 19
);
  logic              ce;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              back_ready;
  logic              swap;
  logic              pixel;
  logic              hsync;
  logic              vsync;
  logic              de;

  // Renderer / pixel-clock side
  modport master (
    output ce, wr_en, wr_addr, wr_data, back_ready,
    input  swap, pixel, hsync, vsync, de
  );

  // Framebuffer side
  modport slave (
    input  ce, wr_en, wr_addr, wr_data, back_ready,
    output swap, pixel, hsync, vsync, de
  );
endinterface

// File: rtl/framebuffer_scanout.sv
// Double-buffered 1-bit framebuffer with raster scanout. The renderer writes
// the back bank at any time; the front bank is streamed one pixel per ce with
// sync and data-enable. Banks flip on entry to vertical blank when the back
// frame is complete, signalled by a one-clk swap pulse.
module framebuffer_scanout #(
  parameter int   HOR_ACTIVE_PIXELS = 640,
  parameter int   VER_ACTIVE_PIXELS = 480,
  parameter int   HOR_FRONT_PORCH   = 16,
  parameter int   HOR_SYNC          = 96,
  parameter int   HOR_BACK_PORCH    = 48,
  parameter int   VER_FRONT_PORCH   = 10,
  parameter int   VER_SYNC          = 2,
  parameter int   VER_BACK_PORCH    = 33,
  parameter logic SYNC_ACTIVE       = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  framebuffer_scanout_if.slave bus
);
  localparam int H_TOTAL       = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
  localparam int V_TOTAL       = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
  localparam int PIXELS        = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam int WR_ADDR_WIDTH = $clog2(PIXELS);
  localparam int MEM_W         = $clog2(2 * PIXELS);
  localparam int H_W           = $clog2(H_TOTAL);
  localparam int V_W           = $clog2(V_TOTAL);
  localparam int HS_START      = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
  localparam int HS_END        = HS_START + HOR_SYNC;
  localparam int VS_START      = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
  localparam int VS_END        = VS_START + VER_SYNC;

  logic [H_W-1:0]           hcnt;
  logic [V_W-1:0]           vcnt;
  logic                     front;
  logic                     swap_pulse;

  // Both banks live in one array: bank b occupies [b*PIXELS, (b+1)*PIXELS).
  logic                     mem [2*PIXELS];

  logic [WR_ADDR_WIDTH-1:0] wr_addr;
  logic                     wr_ok;
  logic [MEM_W-1:0]         wr_index;
  logic [31:0]              rd_addr;
  logic [MEM_W-1:0]         rd_index;
  logic                     active;
  logic                     hsync_on;
  logic                     vsync_on;
  logic                     line_end;
  logic                     frame_end;
  logic                     flip;

  logic                     rd_data_p1;
  logic                     de_p1;
  logic                     hsync_p1;
  logic                     vsync_p1;
  logic                     pixel_p2;
  logic                     de_p2;
  logic                     hsync_p2;
  logic                     vsync_p2;

  assign wr_addr   = bus.wr_addr;
  assign line_end  = (32'(hcnt) == 32'(H_TOTAL - 1));
  assign frame_end = (32'(vcnt) == 32'(V_TOTAL - 1));
  assign active    = (32'(hcnt) < 32'(HOR_ACTIVE_PIXELS)) && (32'(vcnt) < 32'(VER_ACTIVE_PIXELS));
  assign hsync_on  = (32'(hcnt) >= 32'(HS_START)) && (32'(hcnt) < 32'(HS_END));
  assign vsync_on  = (32'(vcnt) >= 32'(VS_START)) && (32'(vcnt) < 32'(VS_END));

  // Flip on the strobe that moves the raster onto (0, VER_ACTIVE_PIXELS).
  assign flip = bus.ce && bus.back_ready && line_end
                && (32'(vcnt) == 32'(VER_ACTIVE_PIXELS - 1));

  // Full-width read address; the bank offset is added before narrowing.
  assign rd_addr  = 32'(vcnt) * 32'(HOR_ACTIVE_PIXELS) + 32'(hcnt);
  assign rd_index = MEM_W'(front ? rd_addr + 32'(PIXELS) : rd_addr);

  // Back bank is the one not selected by front; the range check keeps
  // out-of-range addresses from spilling into the front bank.
  assign wr_ok    = bus.wr_en && (32'(wr_addr) < 32'(PIXELS));
  assign wr_index = MEM_W'(front ? 32'(wr_addr) : 32'(wr_addr) + 32'(PIXELS));

  // Raster counters, bank select and the swap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt       <= '0;
      vcnt       <= '0;
      front      <= 1'b0;
      swap_pulse <= 1'b0;
    end else begin
      swap_pulse <= flip;
      if (flip) begin
        front <= ~front;
      end
      if (bus.ce) begin
        if (line_end) begin
          hcnt <= '0;
          vcnt <= frame_end ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  // Back-bank write port, independent of the pixel strobe.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_index] <= bus.wr_data;
    end
  end

  // ---- stage 1: synchronous front-bank read ----
  // Read data is masked downstream by de, so it needs no reset.
  always_ff @(posedge clk) begin
    if (bus.ce && active) begin
      rd_data_p1 <= mem[rd_index];
    end
  end

  // Stage 1 timing controls derived from the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_p1    <= 1'b0;
      hsync_p1 <= ~SYNC_ACTIVE;
      vsync_p1 <= ~SYNC_ACTIVE;
    end else if (bus.ce) begin
      de_p1    <= active;
      hsync_p1 <= hsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_p1 <= vsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  // ---- stage 2: aligned output registers ----
  // Pixel is gated by the aligned de so blanking always drives 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_p2 <= 1'b0;
      de_p2    <= 1'b0;
      hsync_p2 <= ~SYNC_ACTIVE;
      vsync_p2 <= ~SYNC_ACTIVE;
    end else if (bus.ce) begin
      pixel_p2 <= de_p1 & rd_data_p1;
      de_p2    <= de_p1;
      hsync_p2 <= hsync_p1;
      vsync_p2 <= vsync_p1;
    end
  end

  assign bus.swap  = swap_pulse;
  assign bus.pixel = pixel_p2;
  assign bus.de    = de_p2;
  assign bus.hsync = hsync_p2;
  assign bus.vsync = vsync_p2;
endmodule
